// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pkg                                                                   |
// | Shared 7-segment codes and reader state type.                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package seg7_pkg;

    // Segment patterns, bit0=a ... bit6=g, active high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h67;

    localparam logic [3:0] SEG_INVALID_DIGIT = 4'hF;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETTLE      = 3'd1,
        CAPTURE     = 3'd2,
        HOLD        = 3'd3,
        WAIT_CHANGE = 3'd4
    } seg7_rd_state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_encoder                                                               |
// | Combinational segment-pattern to BCD encoder; flags non-legal patterns.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       invalid
);

    always_comb begin
        digit   = SEG_INVALID_DIGIT;
        invalid = 1'b1;
        case (seg)
            SEG_0: begin digit = 4'd0; invalid = 1'b0; end
            SEG_1: begin digit = 4'd1; invalid = 1'b0; end
            SEG_2: begin digit = 4'd2; invalid = 1'b0; end
            SEG_3: begin digit = 4'd3; invalid = 1'b0; end
            SEG_4: begin digit = 4'd4; invalid = 1'b0; end
            SEG_5: begin digit = 4'd5; invalid = 1'b0; end
            SEG_6: begin digit = 4'd6; invalid = 1'b0; end
            SEG_7: begin digit = 4'd7; invalid = 1'b0; end
            SEG_8: begin digit = 4'd8; invalid = 1'b0; end
            SEG_9: begin digit = 4'd9; invalid = 1'b0; end
            default: begin
                digit   = SEG_INVALID_DIGIT;
                invalid = 1'b1;
            end
        endcase
    end

endmodule : seg7_encoder
`default_nettype wire

// File: rtl/seg7_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_reader                                                                |
// | Reads a multiplexed 7-segment display back to BCD digits with valid/ready. |
// | Optional SEG7_RD_SYNC_EN adds a two-flop synchronizer on the pins.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    seg_i,
    input  logic [NUM_DIGITS-1:0]         dig_sel_i,
    output logic [3:0]                    digit_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          invalid_o,
    output logic                          valid_o,
    input  logic                          ready_i
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam int PAIR_W = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [PAIR_W-1:0]     pin_pair;
    logic [PAIR_W-1:0]     sample_q;
    logic [PAIR_W-1:0]     latch_q, latch_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    seg7_rd_state_t        state_q, state_d;
    logic [NUM_DIGITS-1:0] sample_sel;
    logic                  sample_onehot;
    logic                  pair_differs;
    logic                  accept;
    logic [3:0]            enc_digit;
    logic                  enc_invalid;
    logic [IDX_W-1:0]      enc_idx;

`ifdef SEG7_RD_SYNC_EN
    logic [PAIR_W-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {dig_sel_i, seg_i};
            sync_q2 <= sync_q1;
        end
    end

    assign pin_pair = sync_q2;
`else
    assign pin_pair = {dig_sel_i, seg_i};
`endif

    assign sample_sel    = sample_q[PAIR_W-1:7];
    assign sample_onehot = (sample_sel != '0) &&
                           ((sample_sel & (sample_sel - NUM_DIGITS'(1))) == '0);
    assign pair_differs  = (sample_q != latch_q);
    assign accept        = (state_q == HOLD) && valid_o && ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sample_q <= '0;
            latch_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= pin_pair;
            latch_q  <= latch_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sample_onehot) begin
                    latch_d = sample_q;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // A change on the final count still wins over the capture
                if (!sample_onehot) begin
                    state_d = IDLE;
                end else if (pair_differs) begin
                    latch_d = sample_q;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    state_d = WAIT_CHANGE;
                end
            end
            WAIT_CHANGE: begin
                if (pair_differs) begin
                    if (sample_onehot) begin
                        latch_d = sample_q;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    seg7_encoder u_encoder (
        .seg     (latch_q[6:0]),
        .digit   (enc_digit),
        .invalid (enc_invalid)
    );

    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (latch_q[7+i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_o     <= '0;
            digit_idx_o <= '0;
            invalid_o   <= 1'b0;
            valid_o     <= 1'b0;
        end else if (state_q == CAPTURE) begin
            digit_o     <= enc_digit;
            digit_idx_o <= enc_idx;
            invalid_o   <= enc_invalid;
            valid_o     <= 1'b1;
        end else if (accept) begin
            valid_o <= 1'b0;
        end
    end

endmodule : seg7_reader
`default_nettype wire

// File: tb/tb_seg7_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg7_reader                                                             |
// | Self-checking bench for seg7_reader: vectors, corner sequences, random.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seg7_reader;

    localparam int ND = 4;
    localparam int SC = 4;
`ifdef SEG7_RD_SYNC_EN
    localparam int PIPE = 3;
`else
    localparam int PIPE = 1;
`endif
    localparam int LAT = SC + 2 + PIPE;

    localparam logic [6:0] CODES [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_i = '0;
    logic [ND-1:0] dig_sel_i = '0;
    logic          ready_i = 1'b0;
    logic [3:0]    digit_o;
    logic [1:0]    digit_idx_o;
    logic          invalid_o;
    logic          valid_o;

    always #5 clk = ~clk;

    seg7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_i       (seg_i),
        .dig_sel_i   (dig_sel_i),
        .digit_o     (digit_o),
        .digit_idx_o (digit_idx_o),
        .invalid_o   (invalid_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a digit is reported once it has been seen SC+1 times in
    // a row as a one-hot pair, and not again until the display shows something else.
    logic [10:0] m_pipe [PIPE];
    logic [10:0] m_run_pair, m_rep, m_skip;
    bit          m_skip_v, m_cap, m_valid, m_inv;
    int          m_run;
    logic [3:0]  m_digit;
    logic [1:0]  m_idx;

    function automatic bit is_onehot(input logic [3:0] s);
        return $countones(s) == 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PIPE; i++) m_pipe[i] = '0;
        m_run_pair = '0; m_rep = '0; m_skip = '0;
        m_skip_v = 0; m_cap = 0; m_valid = 0; m_inv = 0;
        m_run = 0; m_digit = '0; m_idx = '0;
    endtask

    task automatic model_report(input logic [10:0] p);
        m_digit = 4'hF;
        m_inv   = 1;
        for (int i = 0; i < 10; i++) begin
            if (p[6:0] == CODES[i]) begin
                m_digit = 4'(i);
                m_inv   = 0;
            end
        end
        m_idx = '0;
        for (int i = 0; i < ND; i++) if (p[7+i]) m_idx = 2'(i);
        m_valid = 1;
    endtask

    task automatic model_step();
        logic [10:0] x;
        x = m_pipe[PIPE-1];
        for (int i = PIPE - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = {dig_sel_i, seg_i};
        if (m_valid) begin
            if (ready_i) begin
                m_valid  = 0;
                m_skip   = m_rep;
                m_skip_v = 1;
                m_run    = 0;
            end
        end else if (m_cap) begin
            model_report(m_rep);
            m_cap = 0;
        end else if (!is_onehot(x[10:7])) begin
            m_run    = 0;
            m_skip_v = 0;
        end else if (!(m_skip_v && x == m_skip)) begin
            m_skip_v = 0;
            if (m_run > 0 && x == m_run_pair) begin
                m_run++;
            end else begin
                m_run_pair = x;
                m_run      = 1;
            end
            if (m_run == SC + 1) begin
                m_cap = 1;
                m_rep = m_run_pair;
                m_run = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        check("model", {24'h0, valid_o, invalid_o, digit_idx_o, digit_o},
              {24'h0, m_valid, m_inv, m_idx, m_digit});
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        while (valid_o !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(valid_o), 32'd1);
    endtask

    task automatic set_pins(input logic [6:0] s, input logic [3:0] d);
        seg_i     = s;
        dig_sel_i = d;
    endtask

    typedef struct {
        logic [6:0] seg;
        logic [3:0] sel;
        logic [3:0] dig;
        logic [1:0] idx;
        logic       inv;
    } vec_t;

    vec_t vecs [12];
    logic [3:0] cap_d [8];
    logic [1:0] cap_i [8];
    int cap_n;

    initial begin
        vecs[0]  = '{7'h3F, 4'b0001, 4'd0, 2'd0, 1'b0};
        vecs[1]  = '{7'h06, 4'b0010, 4'd1, 2'd1, 1'b0};
        vecs[2]  = '{7'h5B, 4'b0100, 4'd2, 2'd2, 1'b0};
        vecs[3]  = '{7'h4F, 4'b1000, 4'd3, 2'd3, 1'b0};
        vecs[4]  = '{7'h66, 4'b0001, 4'd4, 2'd0, 1'b0};
        vecs[5]  = '{7'h6D, 4'b0010, 4'd5, 2'd1, 1'b0};
        vecs[6]  = '{7'h7D, 4'b0100, 4'd6, 2'd2, 1'b0};
        vecs[7]  = '{7'h07, 4'b1000, 4'd7, 2'd3, 1'b0};
        vecs[8]  = '{7'h7F, 4'b0001, 4'd8, 2'd0, 1'b0};
        vecs[9]  = '{7'h67, 4'b0010, 4'd9, 2'd1, 1'b0};
        vecs[10] = '{7'h00, 4'b0100, 4'hF, 2'd2, 1'b1};
        vecs[11] = '{7'h7E, 4'b1000, 4'hF, 2'd3, 1'b1};

        // Reset values, then first capture latency
        model_reset();
        set_pins(7'h5B, 4'b0100);
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 0);
        check("rst_digit", 32'(digit_o), 0);
        check("rst_idx", 32'(digit_idx_o), 0);
        check("rst_invalid", 32'(invalid_o), 0);
        rst_n = 1'b1;
        for (int i = 0; i < LAT - 1; i++) tick();
        check("lat_early", 32'(valid_o), 0);
        tick();
        check("lat_valid", 32'(valid_o), 1);
        check("lat_digit", 32'(digit_o), 2);
        check("lat_idx", 32'(digit_idx_o), 2);
        check("lat_invalid", 32'(invalid_o), 0);
        ready_i = 1'b1;
        tick();
        check("accept_clear", 32'(valid_o), 0);

        // Glitching segments never settle
        for (int i = 0; i < 20; i++) begin
            set_pins(((i / 2) % 2 == 0) ? 7'h07 : 7'h06, 4'b0001);
            tick();
            check("glitch_novalid", 32'(valid_o), 0);
        end
        set_pins(7'h07, 4'b0001);
        for (int i = 0; i < LAT - 1; i++) tick();
        check("glitch_early", 32'(valid_o), 0);
        tick();
        check("glitch_valid", 32'(valid_o), 1);
        check("glitch_digit", 32'(digit_o), 7);
        tick();
        check("glitch_once", 32'(valid_o), 0);

        // Backpressure: outputs frozen while held
        ready_i = 1'b0;
        set_pins(7'h67, 4'b0001);
        wait_valid("bp_first", 20);
        check("bp_digit", 32'(digit_o), 9);
        set_pins(7'h3F, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 32'(valid_o), 1);
            check("bp_hold_digit", 32'(digit_o), 9);
        end
        ready_i = 1'b1;
        tick();
        check("bp_accept", 32'(valid_o), 0);
        wait_valid("bp_next", 20);
        check("bp_next_digit", 32'(digit_o), 0);
        tick();

        // Reset while a capture is pending
        ready_i = 1'b0;
        set_pins(7'h4F, 4'b0010);
        wait_valid("mid_rst_pre", 20);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid", 32'(valid_o), 0);
        check("mid_rst_digit", 32'(digit_o), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) tick();
        check("post_rst_valid", 32'(valid_o), 1);
        check("post_rst_digit", 32'(digit_o), 3);
        check("post_rst_idx", 32'(digit_idx_o), 1);
        ready_i = 1'b1;
        tick();

        // Invalid pattern and illegal select
        set_pins(7'h49, 4'b1000);
        wait_valid("inv", 20);
        check("inv_digit", 32'(digit_o), 32'hF);
        check("inv_flag", 32'(invalid_o), 1);
        check("inv_idx", 32'(digit_idx_o), 3);
        tick();
        set_pins(7'h3F, 4'b0110);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("illegal_sel", 32'(valid_o), 0);
        end

        // Scan through four digits
        cap_n = 0;
        for (int d = 0; d < 4; d++) begin
            set_pins(CODES[d+1], 4'(1 << d));
            for (int k = 0; k < 8; k++) begin
                tick();
                if (valid_o === 1'b1) begin
                    if (cap_n < 8) begin
                        cap_d[cap_n] = digit_o;
                        cap_i[cap_n] = digit_idx_o;
                    end
                    cap_n++;
                end
            end
        end
        check("scan_count", 32'(cap_n), 4);
        for (int d = 0; d < 4 && d < cap_n; d++) begin
            check("scan_digit", 32'(cap_d[d]), 32'(d + 1));
            check("scan_idx", 32'(cap_i[d]), 32'(d));
        end

        // Table of patterns
        for (int v = 0; v < 12; v++) begin
            set_pins(7'h00, 4'b0000);
            tick();
            set_pins(vecs[v].seg, vecs[v].sel);
            wait_valid("vec", 20);
            check("vec_digit", 32'(digit_o), 32'(vecs[v].dig));
            check("vec_idx", 32'(digit_idx_o), 32'(vecs[v].idx));
            check("vec_invalid", 32'(invalid_o), 32'(vecs[v].inv));
            tick();
        end

        // Randomized traffic against the model
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 7) == 0) dig_sel_i = 4'($urandom);
                else dig_sel_i = 4'(1 << $urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) seg_i = 7'($urandom);
                else seg_i = CODES[$urandom_range(0, 9)];
            end
            ready_i = ($urandom_range(0, 3) != 0);
            if (t == 700) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("rand_rst", 32'(valid_o), 0);
            end
            if (t == 703) rst_n = 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seg7_reader
`default_nettype wire

// File: doc/seg7_reader.md
# seg7_reader

Captures the segment and digit-select lines of a multiplexed, common-cathode 7-segment display and encodes each stable digit back to a 4-bit BCD value with a valid/ready handshake. It is the inverse of the team's BCD-to-7-segment decoder: segment pattern in, digit out. It sits between the display pins of an external board and the JTAG DPI readback path, so the host can check what a display actually shows.

## Interface
- NUM_DIGITS, 4: number of multiplexed digit positions, ≥2.
- STABLE_CYCLES, 8: consecutive cycles the sampled {dig_sel, seg} pair must be unchanged before capture, ≥2.
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_i  input  7  segment lines, active high, bit0=a … bit6=g (same bit order as the decoder).
- dig_sel_i  input  NUM_DIGITS  one-hot, active-high digit enable.
- digit_o  output  4  captured BCD value; 4'hF when the pattern is invalid.
- digit_idx_o  output  $clog2(NUM_DIGITS)  index of the set bit of dig_sel_i at capture.
- invalid_o  output  1  captured pattern is not one of the ten legal codes.
- valid_o  output  1  capture available; held until accepted.
- ready_i  input  1  consumer accepts on valid_o && ready_i.

## Operation
- Legal codes: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h67. Any other pattern gives digit_o=4'hF and invalid_o=1. 7'h00, a blanked digit, is also invalid.
- The sample register captures {dig_sel_i, seg_i} every cycle. This is the "sampled pair".
- The FSM has five states: IDLE, SETTLE, CAPTURE, HOLD and WAIT_CHANGE.
- IDLE: if the sampled dig_sel is one-hot, latch the pair, clear the counter and go to SETTLE. Otherwise stay in IDLE.
- SETTLE:
  - If the sampled dig_sel is not one-hot, go to IDLE.
  - Else if the sampled pair differs from the latch, re-latch it and clear the counter.
  - Else increment the counter. When the counter reaches STABLE_CYCLES-1, go to CAPTURE.
- CAPTURE: takes one cycle. It encodes the latch, registers digit_o, digit_idx_o and invalid_o, sets valid_o and goes to HOLD.
- HOLD: outputs are frozen and input changes are ignored. On valid_o && ready_i, clear valid_o and go to WAIT_CHANGE.
- WAIT_CHANGE: stay while the sampled pair equals the latch, so each stable digit is reported once. On a difference, go to SETTLE if dig_sel is one-hot (re-latch, clear the counter), else go to IDLE.
- The counter is $clog2(STABLE_CYCLES) bits wide and never wraps, because it is cleared on entry to SETTLE and left at CAPTURE.

## Timing
- Reset values:
  - valid_o=0, invalid_o=0, digit_o=0, digit_idx_o=0.
  - State is IDLE.
  - Counter, latch and sample/sync registers are all 0.
- Latency L (macro off): pins change at edge N and then stay constant, and valid_o is high after edge N+STABLE_CYCLES+3. This breaks down as:
  - sample at N+1;
  - latch at N+2;
  - STABLE_CYCLES cycles in SETTLE;
  - CAPTURE.
- With SEG7_RD_SYNC_EN, L increases by 2.
- ready_i may be high before valid_o. In that case valid_o is high for exactly one cycle.
- A change at the same edge as the final count increment restarts SETTLE; there is no capture.
- Asserting rst_n low mid-operation clears everything immediately, including a pending valid_o. The pending capture is lost.

## Configuration
- SEG7_RD_SYNC_EN defined: a two-flop synchronizer on seg_i and dig_sel_i precedes the sample register. Use this for asynchronous board pins.
- SEG7_RD_SYNC_EN undefined: the sample register takes the ports directly. Use this when the inputs are already in the clk domain (simulation, DPI loopback).

## Structure
- Package seg7_pkg holds:
  - the SEG_0…SEG_9 constants, shared with the decoder;
  - the SEG_INVALID_DIGIT constant (4'hF);
  - the state enum seg7_rd_state_t.
- Sub-module seg7_encoder: combinational, with seg[6:0] in and digit[3:0], invalid out. It is instantiated once on the latch output.

## Test plan
All scenarios use NUM_DIGITS=4, STABLE_CYCLES=4, macro off.
- Reset: hold rst_n=0 → all outputs 0. Release with seg_i=7'h5B, dig_sel_i=4'b0100 stable → after L=7 cycles valid_o=1, digit_o=2, digit_idx_o=2, invalid_o=0.
- Glitch: seg_i toggles between 7'h06 and 7'h07 every 2 cycles for 20 cycles → valid_o stays 0. Then hold 7'h07 → one capture, digit_o=7, 7 cycles after the last change.
- Backpressure: capture 9 (7'h67, sel 4'b0001) with ready_i=0 for 10 cycles while the inputs change to 7'h3F → digit_o stays 9 and valid_o stays 1. Raise ready_i → accepted. Next capture is 0, 7 cycles after WAIT_CHANGE sees the difference.
- Invalid and illegal select:
  - seg_i=7'h49 on sel 4'b1000 → digit_o=4'hF, invalid_o=1, digit_idx_o=3.
  - dig_sel_i=4'b0110 for 10 cycles → no capture.
- Scan: cycle dig_sel through all 4 digits showing 1,2,3,4, each held 8 cycles, ready_i=1 → four captures in order with idx 0..3. No duplicates while a digit is held.
- Sync build: repeat the first scenario with SEG7_RD_SYNC_EN → L=9.
